// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer and register file wrapped around an external combinational ALU.
// Runs operand fetch, execute and writeback for one 16-bit instruction per start handshake.
module alu_seq_ctrl #(
  parameter int unsigned NREG = 8,
  parameter int unsigned W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s,
  input  logic [15:0]  in,
  output logic         w,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_out,
  input  logic [2:0]   alu_stat,
  output logic [W-1:0] C,
  output logic         Z,
  output logic         V,
  output logic         N,
  input  logic [2:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [2:0] {
    StWait, StDecode, StImm, StGetA, StGetB, StExec, StWrite
  } state_e;

  state_e       state_q, state_d;
  logic [15:0]  ir_q, ir_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] c_q, c_d;
  logic [2:0]   nvz_q, nvz_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [1:0]   alu_op_q, alu_op_d;
  logic [W-1:0] rf_q [NREG];
  logic [W-1:0] rf_d [NREG];

  logic [2:0]   opcode;
  logic [1:0]   op;
  logic [2:0]   rn, rd, rm;
  logic [1:0]   sh;
  logic [7:0]   imm8;
  logic         is_mov_imm, is_mov_reg, is_alu, is_cmp;
  logic [W-1:0] rm_val, rm_shifted;

  assign opcode     = ir_q[15:13];
  assign op         = ir_q[12:11];
  assign rn         = ir_q[10:8];
  assign rd         = ir_q[7:5];
  assign sh         = ir_q[4:3];
  assign rm         = ir_q[2:0];
  assign imm8       = ir_q[7:0];
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign rm_val = rf_q[rm];

  always_comb begin
    rm_shifted = rm_val;
    case (sh)
      2'b01:   rm_shifted = {rm_val[W-2:0], 1'b0};
      2'b10:   rm_shifted = {1'b0, rm_val[W-1:1]};
      2'b11:   rm_shifted = {rm_val[W-1], rm_val[W-1:1]};
      default: rm_shifted = rm_val;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    nvz_d    = nvz_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rf_d     = rf_q;
    case (state_q)
      StWait: begin
        if (s) begin
          ir_d    = in;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Illegal instructions use the IMM slot as a no-write bubble (2-edge turnaround).
        if (is_alu)          state_d = StGetA;
        else if (is_mov_reg) state_d = StGetB;
        else                 state_d = StImm;
      end
      StImm: begin
        if (is_mov_imm) rf_d[rn] = {{(W-8){imm8[7]}}, imm8};
        state_d = StWait;
      end
      StGetA: begin
        a_d     = rf_q[rn];
        state_d = StGetB;
      end
      StGetB: begin
        // ALU inputs are registered here so they are stable through EXEC and hold afterwards.
        b_d      = rm_val;
        alu_a_d  = is_alu ? a_q : '0;
        alu_b_d  = rm_shifted;
        alu_op_d = is_alu ? op : 2'b00;
        state_d  = StExec;
      end
      StExec: begin
        c_d = alu_out;
        if (is_alu) nvz_d = alu_stat;
        state_d = is_cmp ? StWait : StWrite;
      end
      StWrite: begin
        rf_d[rd] = c_q;
        state_d  = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StWait;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      nvz_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      nvz_q    <= nvz_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign w        = (state_q == StWait);
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign C        = c_q;
  assign N        = nvz_q[2];
  assign V        = nvz_q[1];
  assign Z        = nvz_q[0];
  assign dbg_data = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the external ALU.
// Expected register, flag and latency values are hand-computed per instruction.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [15:0] alu_a, alu_b, alu_out, C, dbg_data;
  logic [1:0]  alu_op;
  logic [2:0]  alu_stat, dbg_sel;
  logic        Z, V, N;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  logic [15:0] rv;

  alu_seq_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .in(instr), .w(w),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_stat(alu_stat),
    .C(C), .Z(Z), .V(V), .N(N),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU: stat = {N, V, Z}
  always_comb begin
    logic [15:0] r;
    logic        ov;
    r  = '0;
    ov = 1'b0;
    case (alu_op)
      2'b00: begin r = alu_a + alu_b; ov = (alu_a[15] == alu_b[15]) && (r[15] != alu_a[15]); end
      2'b01: begin r = alu_a - alu_b; ov = (alu_a[15] != alu_b[15]) && (r[15] != alu_a[15]); end
      2'b10: r = alu_a & alu_b;
      default: r = ~alu_b;
    endcase
    alu_out  = r;
    alu_stat = {r[15], ov, (r == 16'h0)};
  end

  task automatic issue(input logic [15:0] ins);
    @(negedge clk);
    instr = ins;
    s = 1'b1;
    @(posedge clk);
    #1;
    s = 1'b0;
    edge_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_cnt++;
    end
  endtask

  task automatic wait_done();
    while (!w && edge_cnt < 40) step(1);
  endtask

  task automatic rd(input logic [2:0] sel, output logic [15:0] v);
    dbg_sel = sel;
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; instr = '0; dbg_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (w !== 1'b1) begin bad++; $display("FAIL reset_w got=%b exp=1", w); end
    total++; if (C !== 16'h0) begin bad++; $display("FAIL reset_c got=%h exp=0000", C); end
    total++; if ({N, V, Z} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {N, V, Z});
    end
    total++; if ({alu_op, alu_a, alu_b} !== 34'h0) begin
      bad++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_op, alu_a, alu_b);
    end
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), rv);
      total++; if (rv !== 16'h0) begin bad++; $display("FAIL reset_r%0d got=%h exp=0000", i, rv); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mov_imm();
    issue(16'hD005);
    total++; if (w !== 1'b0) begin bad++; $display("FAIL movi_busy got=%b exp=0", w); end
    wait_done();
    total++; if (edge_cnt !== 2) begin bad++; $display("FAIL movi_lat got=%0d exp=2", edge_cnt); end
    issue(16'hD1FE);
    wait_done();
    total++; if (edge_cnt !== 2) begin bad++; $display("FAIL movi2_lat got=%0d exp=2", edge_cnt); end
    rd(3'd0, rv);
    total++; if (rv !== 16'h0005) begin bad++; $display("FAIL movi_r0 got=%h exp=0005", rv); end
    rd(3'd1, rv);
    total++; if (rv !== 16'hFFFE) begin bad++; $display("FAIL movi_r1 got=%h exp=fffe", rv); end
    total++; if ({N, V, Z} !== 3'b000) begin
      bad++; $display("FAIL movi_flags got=%b exp=000", {N, V, Z});
    end
  endtask

  task automatic test_add();
    issue(16'hA041);
    step(3);
    total++; if ({alu_op, alu_a, alu_b} !== {2'b00, 16'h0005, 16'hFFFE}) begin
      bad++; $display("FAIL add_exec got=%b/%h/%h exp=00/0005/fffe", alu_op, alu_a, alu_b);
    end
    wait_done();
    total++; if (edge_cnt !== 5) begin bad++; $display("FAIL add_lat got=%0d exp=5", edge_cnt); end
    rd(3'd2, rv);
    total++; if (rv !== 16'h0003) begin bad++; $display("FAIL add_r2 got=%h exp=0003", rv); end
    total++; if (C !== 16'h0003) begin bad++; $display("FAIL add_c got=%h exp=0003", C); end
    total++; if ({N, V, Z} !== 3'b000) begin
      bad++; $display("FAIL add_flags got=%b exp=000", {N, V, Z});
    end
  endtask

  task automatic test_shift_cmp();
    issue(16'hD37F);
    wait_done();
    issue(16'hA38B);
    step(3);
    total++; if (alu_b !== 16'h00FE) begin bad++; $display("FAIL lsl_b got=%h exp=00fe", alu_b); end
    wait_done();
    rd(3'd4, rv);
    total++; if (rv !== 16'h017D) begin bad++; $display("FAIL lsl_r4 got=%h exp=017d", rv); end
    issue(16'hAB03);
    wait_done();
    total++; if (edge_cnt !== 4) begin bad++; $display("FAIL cmp_lat got=%0d exp=4", edge_cnt); end
    total++; if ({N, V, Z} !== 3'b001) begin
      bad++; $display("FAIL cmp_flags got=%b exp=001", {N, V, Z});
    end
    rd(3'd0, rv);
    total++; if (rv !== 16'h0005) begin bad++; $display("FAIL cmp_r0 got=%h exp=0005", rv); end
    rd(3'd4, rv);
    total++; if (rv !== 16'h017D) begin bad++; $display("FAIL cmp_r4 got=%h exp=017d", rv); end
  endtask

  task automatic test_mov_reg();
    issue(16'hC0B1);
    step(2);
    total++; if ({alu_op, alu_a, alu_b} !== {2'b00, 16'h0000, 16'h7FFF}) begin
      bad++; $display("FAIL movr_exec got=%b/%h/%h exp=00/0000/7fff", alu_op, alu_a, alu_b);
    end
    wait_done();
    total++; if (edge_cnt !== 4) begin bad++; $display("FAIL movr_lat got=%0d exp=4", edge_cnt); end
    rd(3'd5, rv);
    total++; if (rv !== 16'h7FFF) begin bad++; $display("FAIL lsr_r5 got=%h exp=7fff", rv); end
    total++; if ({N, V, Z} !== 3'b001) begin
      bad++; $display("FAIL movr_flags got=%b exp=001", {N, V, Z});
    end
    issue(16'hC0F9);
    wait_done();
    rd(3'd7, rv);
    total++; if (rv !== 16'hFFFF) begin bad++; $display("FAIL asr_r7 got=%h exp=ffff", rv); end
    issue(16'hAD01);
    wait_done();
    total++; if (edge_cnt !== 4) begin bad++; $display("FAIL cmp2_lat got=%0d exp=4", edge_cnt); end
    total++; if ({N, V, Z} !== 3'b110) begin
      bad++; $display("FAIL cmp2_flags got=%b exp=110", {N, V, Z});
    end
    total++; if (C !== 16'h8001) begin bad++; $display("FAIL cmp2_c got=%h exp=8001", C); end
  endtask

  task automatic test_illegal();
    issue(16'hE000);
    wait_done();
    total++; if (edge_cnt !== 2) begin bad++; $display("FAIL ill_lat got=%0d exp=2", edge_cnt); end
    total++; if ({N, V, Z} !== 3'b110) begin
      bad++; $display("FAIL ill_flags got=%b exp=110", {N, V, Z});
    end
    total++; if (C !== 16'h8001) begin bad++; $display("FAIL ill_c got=%h exp=8001", C); end
    rd(3'd0, rv);
    total++; if (rv !== 16'h0005) begin bad++; $display("FAIL ill_r0 got=%h exp=0005", rv); end
  endtask

  task automatic test_busy_start();
    issue(16'hA041);
    instr = 16'hD655;
    s = 1'b1;
    step(2);
    s = 1'b0;
    wait_done();
    total++; if (edge_cnt !== 5) begin bad++; $display("FAIL busy_lat got=%0d exp=5", edge_cnt); end
    step(1);
    total++; if (w !== 1'b1) begin bad++; $display("FAIL busy_idle got=%b exp=1", w); end
    rd(3'd6, rv);
    total++; if (rv !== 16'h0000) begin bad++; $display("FAIL busy_r6 got=%h exp=0000", rv); end
    rd(3'd2, rv);
    total++; if (rv !== 16'h0003) begin bad++; $display("FAIL busy_r2 got=%h exp=0003", rv); end
  endtask

  task automatic test_reset_mid();
    dbg_sel = 3'd6;
    issue(16'hA0C1);
    step(3);
    #2;
    reset = 1'b1;
    #1;
    total++; if (w !== 1'b1) begin bad++; $display("FAIL rmid_w got=%b exp=1", w); end
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL rmid_r6 got=%h exp=0000", dbg_data); end
    total++; if ({C, N, V, Z} !== 19'h0) begin
      bad++; $display("FAIL rmid_cf got=%h/%b exp=0/000", C, {N, V, Z});
    end
    total++; if (alu_a !== 16'h0) begin bad++; $display("FAIL rmid_alua got=%h exp=0000", alu_a); end
    @(negedge clk);
    reset = 1'b0;
    step(2);
    rd(3'd6, rv);
    total++; if ({w, rv} !== 17'h10000) begin
      bad++; $display("FAIL rmid_after got=%b/%h exp=1/0000", w, rv);
    end
  endtask

  task automatic test_after_reset();
    issue(16'hD609);
    wait_done();
    rd(3'd6, rv);
    total++; if (rv !== 16'h0009) begin bad++; $display("FAIL post_r6 got=%h exp=0009", rv); end
    issue(16'hB8E6);
    wait_done();
    total++; if (edge_cnt !== 5) begin bad++; $display("FAIL mvn_lat got=%0d exp=5", edge_cnt); end
    rd(3'd7, rv);
    total++; if (rv !== 16'hFFF6) begin bad++; $display("FAIL mvn_r7 got=%h exp=fff6", rv); end
    total++; if ({N, V, Z} !== 3'b100) begin
      bad++; $display("FAIL mvn_flags got=%b exp=100", {N, V, Z});
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_shift_cmp();
    test_mov_reg();
    test_illegal();
    test_busy_start();
    test_reset_mid();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
